cam_vip_packetizer: RTL and testbench
=====================================

Name: cam_vip_packetizer

Overview:
- Converts a free-running 30-bit camera pixel stream (3 x 10-bit colour per clock, no backpressure) into Avalon-ST Video (VIP) packets on a 30-bit, 3-symbols-per-beat source.
- Per frame it emits one control packet (width/height/interlace), then one video packet.
- Sits directly upstream of the 10-to-8-bit VIP colour-depth reducer and feeds its sink.
- Absorbs header-insertion cycles and downstream stalls in an internal FIFO.

Parameters:
- IMG_WIDTH, 800, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- FIFO_DEPTH, 64, pixel FIFO entries; power of two, at least 8.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- pix_data  in  30  pixel {C2[29:20], C1[19:10], C0[9:0]}.
- pix_valid  in  1  pixel qualifier.
- pix_sof  in  1  first pixel of a frame; only meaningful with pix_valid.
- source_data  out  30  VIP beat.
- source_valid  out  1  beat valid.
- source_ready  in  1  downstream ready (readyLatency 0).
- source_sop  out  1  start of packet.
- source_eop  out  1  end of packet.
- ovf_clr  in  1  clears ovf_sticky.
- ovf_sticky  out  1  set when any pixel was dropped.

Behaviour:
- Reset values:
  - source_valid, source_sop, source_eop, source_data, ovf_sticky = 0.
  - FIFO empty; FSM in S_IDLE; input side in drop mode (waits for the first sof).
- Input side:
  - Write {pix_sof, pix_data} when pix_valid and not dropping, or when pix_valid and pix_sof.
  - pix_sof always exits drop mode.
  - pix_valid while the FIFO is full: pixel lost, ovf_sticky <= 1, enter drop mode until the next pix_sof.
  - If pix_sof arrives with the FIFO full, that pixel is also lost and drop mode stays active.
- ovf_clr and a new overflow in the same cycle: ovf_sticky = 1.
- Output stage:
  - Registered. A beat is held stable while source_valid && !source_ready.
  - A new beat loads when !source_valid || source_ready.
- FSM:
  - S_IDLE: FIFO head with sof=1 -> S_C0. Head with sof=0 -> pop and discard (orphan pixel). Empty -> stay.
  - S_C0: header beat, data[3:0]=4'hF, all other bits 0, sop=1.
  - S_C1: sym0=W[15:12], sym1=W[11:8], sym2=W[7:4].
  - S_C2: sym0=W[3:0], sym1=H[15:12], sym2=H[11:8].
  - S_C3: sym0=H[7:4], sym1=H[3:0], sym2=4'h3 (progressive); eop=1.
  - Nibble placement: symbol n nibble at data[10n+3:10n]; the other bits of each symbol are 0.
  - S_VH: video header, data[3:0]=4'h0, sop=1 -> S_PIX.
  - S_PIX: pop and emit the head pixel; the sof bit is ignored only for the first pixel.
    - Pixel counter counts 0 .. W*H-1; eop on the last pixel -> S_IDLE.
    - Head with sof=1 before the count completes -> S_PAD without popping it.
  - S_PAD: emit zero pixels until the count completes, eop on the last one -> S_IDLE. The short frame is thus completed to W*H pixels.
- Latency: the first control beat is valid 2 cycles after the sof pixel is written, if the FIFO was empty and source_ready=1.
- Throughput: 1 beat per cycle while ready. Each frame costs 5 header beats; these must be hidden by camera blanking.
- Counter width is $clog2(W*H). W and H are packed into 16 bits each.

Optional Feature:
- Macro VIP_CTRL_PKT_EN.
- Defined: behaviour as above; S_IDLE goes to S_C0.
- Undefined: S_C0..S_C3 are not compiled; S_IDLE goes straight to S_VH, and only video packets are sent.

Decomposition:
- Package cam_vip_pkg holds:
  - VIP_TYPE_CTRL = 4'hF, VIP_TYPE_VIDEO = 4'h0, VIP_INTERLACE_PROG = 4'h3.
  - The state enum (S_IDLE, S_C0..S_C3, S_VH, S_PIX, S_PAD).
  - A nibble-packing function.
- One sub-module: vip_pix_fifo, a synchronous FIFO.
  - 31-bit wide, show-ahead.
  - Ports: full, empty, push, pop, din, dout.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=8, VIP_CTRL_PKT_EN defined):
- Nominal frame: one frame of 8 pixels with values 1..8, source_ready=1 -> exactly 13 beats in this order:
  - 4 control beats; beat2 carries sym1 nibble = 0, sym2 nibble = 0; beat3 carries sym0 = 0, sym1 = 2, sym2 = 3, with eop.
  - Video header 0 with sop.
  - Pixels 1..8, eop on 8.
- Backpressure: source_ready toggled every cycle during the same frame -> identical beat sequence, no beat changes while stalled, ovf_sticky=0.
- Overflow: source_ready=0 for the first 12 pixels written across two frames -> ovf_sticky=1, and the output still forms complete 8-pixel packets (PAD zeros where needed). ovf_clr pulse -> ovf_sticky=0.
- Short frame: sof, 5 pixels, then a new sof -> first video packet = 5 pixels + 3 zero pixels with eop, then the next frame starts with a control packet.
- Orphan pixels: 3 pixels without sof after reset -> no output beats. A subsequent sof frame is output normally.
- Mid-operation reset: reset_n pulsed low during S_PIX -> outputs 0 next edge, FIFO empty; the next sof frame is complete and correct. Repeat the nominal-frame check with VIP_CTRL_PKT_EN undefined -> 9 beats.

Source files
------------

// File: rtl/cam_vip_pkg.sv
// Shared definitions for the camera-to-VIP packetizer.
//   - VIP packet type / interlace nibbles
//   - packetizer FSM state encoding
//   - FIFO entry layout {sof, pixel}
//   - pack_nibbles(): places one nibble in the low bits of each 10-bit symbol
package cam_vip_pkg;

  localparam logic [3:0] VIP_TYPE_CTRL      = 4'hF;
  localparam logic [3:0] VIP_TYPE_VIDEO     = 4'h0;
  localparam logic [3:0] VIP_INTERLACE_PROG = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_C0,
    S_C1,
    S_C2,
    S_C3,
    S_VH,
    S_PIX,
    S_PAD
  } state_e;

  typedef struct packed {
    logic        sof;
    logic [29:0] data;
  } fifo_entry_t;

  // Symbol n occupies data[10n+9:10n]; header nibbles sit in data[10n+3:10n].
  function automatic logic [29:0] pack_nibbles(input logic [3:0] sym2,
                                               input logic [3:0] sym1,
                                               input logic [3:0] sym0);
    return {6'b0, sym2, 6'b0, sym1, 6'b0, sym0};
  endfunction

endpackage

// File: rtl/vip_pix_fifo.sv
// Synchronous show-ahead FIFO for {sof, pixel} entries.
// dout always presents the head entry; it is valid whenever empty is low.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, din     write request and data (ignored while full)
//   pop           consume the head entry (ignored while empty)
//   dout          head entry
//   full, empty   status flags
module vip_pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define validity,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_vip_packetizer.sv
// Camera pixel stream to Avalon-ST Video (VIP) packetizer.
// Per frame: one control packet (width/height/progressive), then one video
// packet of exactly IMG_WIDTH*IMG_HEIGHT pixels (short frames are zero-padded,
// long frames truncated). A pixel FIFO absorbs header beats and stalls.
// Build option: define VIP_CTRL_PKT_EN to emit control packets; without it
// only video packets are sent.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   pix_data/pix_valid/pix_sof        camera input, no backpressure
//   source_data/valid/ready/sop/eop   VIP source, readyLatency 0
//   ovf_clr, ovf_sticky               dropped-pixel flag and its clear
module cam_vip_packetizer
  import cam_vip_pkg::*;
#(
  parameter int IMG_WIDTH  = 800,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [29:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        ovf_clr,
  output logic        ovf_sticky
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
`ifdef VIP_CTRL_PKT_EN
  localparam logic [15:0] W16 = 16'(IMG_WIDTH);
  localparam logic [15:0] H16 = 16'(IMG_HEIGHT);
`endif

  fifo_entry_t fifo_din, fifo_head;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic        drop_q, drop_d, ovf_q, ovf_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      data_q, data_d;
  logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic             load;

  vip_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(31)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_din = '{sof: pix_sof, data: pix_data};

  // Input side: after a loss the rest of that frame is discarded until a
  // new sof, so the FIFO never holds a frame with a hole in it.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    fifo_push = 1'b0;
    drop_d    = drop_q;
    ovf_d     = ovf_q && !ovf_clr;
    if (pix_valid) begin
      if (fifo_full) begin
        ovf_d  = 1'b1;
        drop_d = 1'b1;
      end else if (pix_sof) begin
        fifo_push = 1'b1;
        drop_d    = 1'b0;
      end else if (!drop_q) begin
        fifo_push = 1'b1;
      end
    end
  end

  // The FSM only advances when the output register can take a new beat.
  assign load = !valid_q || source_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    data_d   = data_q;
    if (load) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      data_d  = '0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (fifo_head.sof) begin
`ifdef VIP_CTRL_PKT_EN
              state_d = S_C0;
`else
              state_d = S_VH;
`endif
            end else begin
              fifo_pop = 1'b1;  // orphan pixel outside any frame
            end
          end
        end
`ifdef VIP_CTRL_PKT_EN
        S_C0: begin
          valid_d = 1'b1;
          sop_d   = 1'b1;
          data_d  = pack_nibbles(4'h0, 4'h0, VIP_TYPE_CTRL);
          state_d = S_C1;
        end
        S_C1: begin
          valid_d = 1'b1;
          data_d  = pack_nibbles(W16[7:4], W16[11:8], W16[15:12]);
          state_d = S_C2;
        end
        S_C2: begin
          valid_d = 1'b1;
          data_d  = pack_nibbles(H16[11:8], H16[15:12], W16[3:0]);
          state_d = S_C3;
        end
        S_C3: begin
          valid_d = 1'b1;
          eop_d   = 1'b1;
          data_d  = pack_nibbles(VIP_INTERLACE_PROG, H16[3:0], H16[7:4]);
          state_d = S_VH;
        end
`endif
        S_VH: begin
          valid_d = 1'b1;
          sop_d   = 1'b1;
          data_d  = pack_nibbles(4'h0, 4'h0, VIP_TYPE_VIDEO);
          cnt_d   = '0;
          state_d = S_PIX;
        end
        S_PIX: begin
          if (!fifo_empty) begin
            // cnt_q == 0 means the head is this frame's own sof pixel.
            if (fifo_head.sof && (cnt_q != '0)) begin
              state_d = S_PAD;  // next frame arrived early: pad this one
            end else begin
              fifo_pop = 1'b1;
              valid_d  = 1'b1;
              data_d   = fifo_head.data;
              if (cnt_q == LAST_PIX) begin
                eop_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          valid_d = 1'b1;
          if (cnt_q == LAST_PIX) begin
            eop_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q  <= 1'b1;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign source_data  = data_q;
  assign source_valid = valid_q;
  assign source_sop   = sop_q;
  assign source_eop   = eop_q;
  assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_cam_vip_packetizer.sv
// Self-checking bench for cam_vip_packetizer (4x2 image, 8-entry FIFO).
// Works with and without VIP_CTRL_PKT_EN; the expected control beats follow
// the same macro.
module tb_cam_vip_packetizer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 8;
  localparam int N = W * H;
`ifdef VIP_CTRL_PKT_EN
  localparam bit CTRL = 1'b1;
`else
  localparam bit CTRL = 1'b0;
`endif

  typedef struct {
    logic [29:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic        sof;
    logic [29:0] data;
  } pix_t;

  typedef struct {
    logic        drive;     // row also drives an input pixel
    logic [29:0] pix;       // input pixel value
    logic [29:0] exp_data;  // expected beat
    logic        exp_sop;
    logic        exp_eop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [29:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        ovf_clr = 1'b0;
  logic        ovf_sticky;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low
  pix_t  in_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  tbl[13];
  int    nrows;

  cam_vip_packetizer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       source_ready = 1'b1;
        1:       source_ready = ~source_ready;
        2:       source_ready = !source_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: source_ready = 1'b0;
      endcase
    end
  end

  // Monitor: collects accepted beats and checks that a stalled beat holds.
  initial begin
    logic [31:0] prev_b;
    bit          prev_stall;
    prev_b     = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'b0, source_valid}, 32'd1);
          check("stall_beat", {source_data, source_sop, source_eop}, prev_b);
        end
        if (source_valid && source_ready)
          got_q.push_back('{data: source_data, sop: source_sop, eop: source_eop});
        prev_stall = source_valid && !source_ready;
        prev_b     = {source_data, source_sop, source_eop};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model at frame level: split logged input pixels into frames
  // (pixels before the first sof are ignored), then each frame becomes
  // headers + exactly N pixels, zero-padded or truncated.
  function automatic logic [29:0] syms(input int s2, input int s1, input int s0);
    return 30'((s2 << 20) | (s1 << 10) | s0);
  endfunction

  function automatic void emit_frame(input logic [29:0] fr[$]);
    if (CTRL) begin
      exp_q.push_back('{data: syms(0, 0, 15), sop: 1'b1, eop: 1'b0});
      exp_q.push_back('{data: syms((W >> 4) & 15, (W >> 8) & 15, (W >> 12) & 15), sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{data: syms((H >> 8) & 15, (H >> 12) & 15, W & 15), sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{data: syms(3, H & 15, (H >> 4) & 15), sop: 1'b0, eop: 1'b1});
    end
    exp_q.push_back('{data: 30'd0, sop: 1'b1, eop: 1'b0});
    for (int k = 0; k < N; k++)
      exp_q.push_back('{data: (k < fr.size()) ? fr[k] : 30'd0, sop: 1'b0, eop: (k == N - 1)});
  endfunction

  function automatic void build_expected();
    logic [29:0] fr[$];
    bit          active;
    exp_q.delete();
    active = 1'b0;
    foreach (in_q[i]) begin
      if (in_q[i].sof) begin
        if (active) emit_frame(fr);
        fr.delete();
        fr.push_back(in_q[i].data);
        active = 1'b1;
      end else if (active) begin
        fr.push_back(in_q[i].data);
      end
    end
    if (active) emit_frame(fr);
  endfunction

  task automatic drive_pix(input logic sof, input logic [29:0] data, input bit log);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = data;
    if (log) in_q.push_back('{sof: sof, data: data});
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) tick();
    got_q.delete();
    in_q.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_beats(input int n, input string tag);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 3000) begin
      tick();
      budget++;
    end
    repeat (20) tick();  // extra beats would show up here
    check({tag, "_beat_count"}, got_q.size(), n);
  endtask

  task automatic compare_model(input string tag);
    build_expected();
    wait_beats(exp_q.size(), tag);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), {2'b0, got_q[i].data}, {2'b0, exp_q[i].data});
      check($sformatf("%s_sop[%0d]", tag, i), {31'b0, got_q[i].sop}, {31'b0, exp_q[i].sop});
      check($sformatf("%s_eop[%0d]", tag, i), {31'b0, got_q[i].eop}, {31'b0, exp_q[i].eop});
    end
  endtask

  // Table-driven nominal frame: pixels 1..8 in, hand-derived beats out.
  task automatic run_table(input string tag, input bit lat);
    int p;
    p = 0;
    for (int i = 0; i < nrows; i++) begin
      if (tbl[i].drive) begin
        drive_pix(p == 0, tbl[i].pix, 1'b0);
        if (lat && p < 2) check($sformatf("%s_lat%0d_valid", tag, p), {31'b0, source_valid}, 32'd0);
        if (lat && p == 2) begin
          check({tag, "_lat2_valid"}, {31'b0, source_valid}, 32'd1);
          check({tag, "_lat2_sop"}, {31'b0, source_sop}, 32'd1);
        end
        p++;
      end
    end
    wait_beats(nrows, tag);
    for (int i = 0; i < nrows && i < got_q.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), {2'b0, got_q[i].data}, {2'b0, tbl[i].exp_data});
      check($sformatf("%s_sop[%0d]", tag, i), {31'b0, got_q[i].sop}, {31'b0, tbl[i].exp_sop});
      check($sformatf("%s_eop[%0d]", tag, i), {31'b0, got_q[i].eop}, {31'b0, tbl[i].exp_eop});
    end
    check({tag, "_ovf"}, {31'b0, ovf_sticky}, 32'd0);
  endtask

  initial begin
    int r;
    logic [29:0] rnd;
    int len;

    // Expected beats for W=4, H=2: W nibbles 0,0,0,4; H nibbles 0,0,0,2.
    r = 0;
    if (CTRL) begin
      tbl[0] = '{drive: 1'b0, pix: '0, exp_data: 30'h000000F, exp_sop: 1'b1, exp_eop: 1'b0};
      tbl[1] = '{drive: 1'b0, pix: '0, exp_data: 30'h0000000, exp_sop: 1'b0, exp_eop: 1'b0};
      tbl[2] = '{drive: 1'b0, pix: '0, exp_data: 30'h0000004, exp_sop: 1'b0, exp_eop: 1'b0};
      tbl[3] = '{drive: 1'b0, pix: '0, exp_data: 30'h0300800, exp_sop: 1'b0, exp_eop: 1'b1};
      r = 4;
    end
    tbl[r] = '{drive: 1'b0, pix: '0, exp_data: 30'h0, exp_sop: 1'b1, exp_eop: 1'b0};
    r++;
    for (int k = 1; k <= 8; k++) begin
      tbl[r] = '{drive: 1'b1, pix: 30'(k), exp_data: 30'(k), exp_sop: 1'b0, exp_eop: (k == 8)};
      r++;
    end
    nrows = r;

    // Reset values.
    #1;
    check("rst_valid", {31'b0, source_valid}, 32'd0);
    check("rst_sop", {31'b0, source_sop}, 32'd0);
    check("rst_eop", {31'b0, source_eop}, 32'd0);
    check("rst_data", {2'b0, source_data}, 32'd0);
    check("rst_ovf", {31'b0, ovf_sticky}, 32'd0);

    // Nominal frame, always ready.
    rdy_mode = 0;
    do_reset();
    run_table("nominal", 1'b1);

    // Same frame under alternating backpressure.
    rdy_mode = 1;
    do_reset();
    run_table("bp", 1'b0);

    // Overflow: downstream stalled while 12 pixels arrive (A: 1..6, B: 7..12).
    // Only the first 8 fit; the rest of B is lost, so A and B get padded.
    rdy_mode = 3;
    do_reset();
    for (int i = 1; i <= 12; i++) drive_pix(i == 1 || i == 7, 30'(i), i <= 8);
    check("ovf_set", {31'b0, ovf_sticky}, 32'd1);
    rdy_mode = 0;
    for (int i = 13; i <= 15; i++) drive_pix(1'b0, 30'(i), 1'b0);
    repeat (30) tick();
    for (int i = 0; i < N; i++) begin
      drive_pix(i == 0, 30'(100 + i), 1'b1);
      tick();
    end
    compare_model("ovf");
    check("ovf_hold", {31'b0, ovf_sticky}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", {31'b0, ovf_sticky}, 32'd0);

    // Short frame: 5 pixels, then a full frame.
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_pix(i == 0, 30'(200 + i), 1'b1);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      drive_pix(i == 0, 30'(300 + i), 1'b1);
      tick();
    end
    compare_model("short");

    // Orphan pixels after reset produce nothing; a following frame is normal.
    do_reset();
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 30'(50 + i), 1'b1);
    repeat (20) tick();
    check("orphan_silent", got_q.size(), 32'd0);
    for (int i = 0; i < N; i++) drive_pix(i == 0, 30'(400 + i), 1'b1);
    compare_model("orphan");

    // Reset in the middle of the video packet, with the next frame queued.
    do_reset();
    for (int i = 0; i < N; i++) drive_pix(i == 0, 30'(500 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive_pix(i == 0, 30'(600 + i), 1'b0);
    begin
      int budget;
      budget = 0;
      while (got_q.size() < 7 && budget < 200) begin
        tick();
        budget++;
      end
      check("midrst_reached_pix", {31'b0, got_q.size() >= 7}, 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, source_valid}, 32'd0);
    check("midrst_sop", {31'b0, source_sop}, 32'd0);
    check("midrst_eop", {31'b0, source_eop}, 32'd0);
    check("midrst_data", {2'b0, source_data}, 32'd0);
    tick();
    check("midrst_valid_edge", {31'b0, source_valid}, 32'd0);
    got_q.delete();
    in_q.delete();
    reset_n = 1'b1;
    repeat (20) tick();
    check("midrst_quiet", got_q.size(), 32'd0);
    for (int i = 0; i < N; i++) drive_pix(i == 0, 30'(700 + i), 1'b1);
    compare_model("midrst");

    // Random frames, random lengths and data, random backpressure. Pixel
    // rate and blanking are low enough that the FIFO cannot overflow.
    rdy_mode = 2;
    do_reset();
    repeat ($urandom_range(0, 3)) begin
      rnd = 30'($urandom());
      drive_pix(1'b0, rnd, 1'b1);
      repeat ($urandom_range(2, 4)) tick();
    end
    for (int f = 0; f < 6; f++) begin
      len = (f == 5) ? N : $urandom_range(1, 12);
      for (int p = 0; p < len; p++) begin
        rnd = 30'($urandom());
        drive_pix(p == 0, rnd, 1'b1);
        repeat ($urandom_range(2, 4)) tick();
      end
      repeat (30) tick();
    end
    compare_model("rand");
    check("rand_ovf", {31'b0, ovf_sticky}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
